// File: rtl/me_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// me_pkg : block geometry constants and fetch-FSM state type
// Revision: 1.0
// ---------------------------------------------------------------------------
package me_pkg;

    localparam int BLK_DIM       = 8;
    localparam int PIX_BITS      = 8;
    localparam int WORD_PIX      = 4;
    localparam int WORDS_PER_BLK = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_READY    = 3'd2,
        S_ANNOUNCE = 3'd3,
        S_STREAM   = 3'd4,
        S_DONE     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cur_word_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cur_word_buf : 16x32 register file, synchronous write, combinational read
// Revision: 1.0
// ---------------------------------------------------------------------------
module cur_word_buf
    import me_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  raddr,
    output logic [31:0] rdata
);

    logic [PIX_BITS*WORD_PIX-1:0] mem_q [WORDS_PER_BLK];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/cur_block_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cur_block_fetch : fetches 8x8 blocks of the current frame in raster order
//                   into a local buffer and streams them to the ME core
// Revision: 1.0
// ---------------------------------------------------------------------------
module cur_block_fetch
    import me_pkg::*;
#(
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64,
    parameter int MEM_AW  = 10,
    localparam int BX_W = (FRAME_W / BLK_DIM > 1) ? $clog2(FRAME_W / BLK_DIM) : 1,
    localparam int BY_W = (FRAME_H / BLK_DIM > 1) ? $clog2(FRAME_H / BLK_DIM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              blk_req,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              next_block,
    input  logic              need_cur,
    output logic [31:0]       cur_in,
    output logic [BX_W-1:0]   blk_x,
    output logic [BY_W-1:0]   blk_y,
    output logic              frame_done
);

    localparam int BLK_COLS = FRAME_W / BLK_DIM;
    localparam int BLK_ROWS = FRAME_H / BLK_DIM;
    localparam int ROW_WORDS = FRAME_W / WORD_PIX;

    state_t             state_q, state_d;
    logic [BX_W-1:0]    bx_q, bx_d;
    logic [BY_W-1:0]    by_q, by_d;
    logic [BX_W-1:0]    blk_x_q, blk_x_d;
    logic [BY_W-1:0]    blk_y_q, blk_y_d;
    logic               req_pend_q, req_pend_d;
    logic [3:0]         k_q, k_d;
    logic [3:0]         out_idx_q, out_idx_d;
    logic               rd_v_q, rd_v_d;
    logic [3:0]         widx_q, widx_d;
    logic               mem_rd_q, mem_rd_d;
    logic [MEM_AW-1:0]  mem_addr_q, mem_addr_d;
    logic               next_block_q, next_block_d;
    logic               frame_done_q, frame_done_d;

    logic               last_blk;
    logic [BX_W-1:0]    nbx;
    logic [BY_W-1:0]    nby;
    logic [3:0]         k_next;
    logic [31:0]        buf_rdata;

    // Word k of block (bx,by): row k>>1 of the block, left or right 4-pixel half.
    function automatic logic [MEM_AW-1:0] word_addr(input logic [BX_W-1:0] bx,
                                                    input logic [BY_W-1:0] by,
                                                    input logic [3:0]      k);
        logic [MEM_AW-1:0] row;
        row = MEM_AW'(by) * MEM_AW'(BLK_DIM) + MEM_AW'(k[3:1]);
        return row * MEM_AW'(ROW_WORDS) + MEM_AW'(bx) * MEM_AW'(2) + MEM_AW'(k[0]);
    endfunction

    assign last_blk = (bx_q == BX_W'(BLK_COLS - 1)) && (by_q == BY_W'(BLK_ROWS - 1));
    assign nbx      = (bx_q == BX_W'(BLK_COLS - 1)) ? '0 : bx_q + BX_W'(1);
    assign nby      = (bx_q == BX_W'(BLK_COLS - 1)) ? by_q + BY_W'(1) : by_q;
    assign k_next   = k_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        bx_d         = bx_q;
        by_d         = by_q;
        blk_x_d      = blk_x_q;
        blk_y_d      = blk_y_q;
        req_pend_d   = req_pend_q | (blk_req && (state_q != S_IDLE));
        k_d          = k_q;
        out_idx_d    = out_idx_q;
        rd_v_d       = 1'b0;
        widx_d       = widx_q;
        mem_rd_d     = mem_rd_q;
        mem_addr_d   = mem_addr_q;
        next_block_d = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bx_d       = '0;
                    by_d       = '0;
                    req_pend_d = 1'b1;
                    k_d        = 4'd0;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = word_addr('0, '0, 4'd0);
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_rd_q) begin
                    rd_v_d = 1'b1;
                    widx_d = k_q;
                    if (k_q == 4'd15) begin
                        mem_rd_d = 1'b0;
                        k_d      = 4'd0;
                    end else begin
                        k_d        = k_next;
                        mem_addr_d = word_addr(bx_q, by_q, k_next);
                    end
                end
                if (rd_v_q && (widx_q == 4'd15)) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                // A request arriving in this very cycle is honoured without waiting for the flag.
                if (req_pend_q || blk_req) begin
                    next_block_d = 1'b1;
                    blk_x_d      = bx_q;
                    blk_y_d      = by_q;
                    state_d      = S_ANNOUNCE;
                end
            end
            S_ANNOUNCE: begin
                req_pend_d = blk_req;
                out_idx_d  = 4'd0;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                if (need_cur) begin
                    out_idx_d = out_idx_q + 4'd1;
                    if (out_idx_q == 4'd15) begin
                        if (last_blk) begin
                            frame_done_d = 1'b1;
                            state_d      = S_DONE;
                        end else begin
                            bx_d       = nbx;
                            by_d       = nby;
                            k_d        = 4'd0;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = word_addr(nbx, nby, 4'd0);
                            state_d    = S_FETCH;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bx_q         <= '0;
            by_q         <= '0;
            blk_x_q      <= '0;
            blk_y_q      <= '0;
            req_pend_q   <= 1'b0;
            k_q          <= 4'd0;
            out_idx_q    <= 4'd0;
            rd_v_q       <= 1'b0;
            widx_q       <= 4'd0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            next_block_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bx_q         <= bx_d;
            by_q         <= by_d;
            blk_x_q      <= blk_x_d;
            blk_y_q      <= blk_y_d;
            req_pend_q   <= req_pend_d;
            k_q          <= k_d;
            out_idx_q    <= out_idx_d;
            rd_v_q       <= rd_v_d;
            widx_q       <= widx_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
            next_block_q <= next_block_d;
            frame_done_q <= frame_done_d;
        end
    end

    cur_word_buf u_buf (
        .clk   (clk),
        .we    (rd_v_q),
        .waddr (widx_q),
        .wdata (mem_rdata),
        .raddr (out_idx_q),
        .rdata (buf_rdata)
    );

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign next_block = next_block_q;
    assign blk_x      = blk_x_q;
    assign blk_y      = blk_y_q;
    assign frame_done = frame_done_q;
    assign cur_in     = ((state_q == S_STREAM) && need_cur) ? buf_rdata : 32'd0;

endmodule
`default_nettype wire
